// File: rtl/ds_sample_pacer.sv
// ---------------------------------------------------------------------------
// ds_sample_pacer
//
// Paces a delta-sigma modulator at a fixed output rate. Incoming PCM samples
// are buffered in a small FIFO and the current sample is presented on the
// modulator's u input. The modulator enable is gated so that exactly one
// output word is taken every period_cfg_i+1 clocks. The block moves on to the
// next input sample every osr_cfg_i+1 output words.
//
// Optional feature macro: DS_PACER_UNDERRUN_MUTE_EN
//   defined     : an underrun loads 0 into mod_u_o (mute)
//   not defined : an underrun leaves mod_u_o at the last sample
//
// Ports
//   clk_i            clock, single domain
//   reset_i          synchronous active-high reset
//   run_i            pacing enable
//   period_cfg_i     output period minus one, in clocks
//   osr_cfg_i        output words per input sample minus one
//   clear_flags_i    clears the sticky underrun/late flags
//   in_valid_i       sample push request
//   in_ready_o       FIFO has space (combinational)
//   in_sample_i      sample to push
//   fifo_level_o     number of FIFO entries
//   mod_en_o         modulator enable (combinational)
//   mod_u_o          modulator input sample
//   mod_y_valid_i    modulator output is valid
//   mod_y_i          modulator output word
//   out_strobe_o     one-cycle pulse, new output word on out_y_o
//   out_y_o          registered output word
//   underrun_o       sticky: a pop found the FIFO empty
//   late_o           sticky: a tick came before the modulator was ready
// ---------------------------------------------------------------------------
module ds_sample_pacer #(
    parameter int IN_BITS     = 16,
    parameter int OUT_BITS    = 7,
    parameter int FIFO_DEPTH  = 4,
    parameter int PERIOD_BITS = 8,
    parameter int OSR_BITS    = 8
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          run_i,
    input  logic [PERIOD_BITS-1:0]        period_cfg_i,
    input  logic [OSR_BITS-1:0]           osr_cfg_i,
    input  logic                          clear_flags_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [IN_BITS-1:0]            in_sample_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          mod_en_o,
    output logic [IN_BITS-1:0]            mod_u_o,
    input  logic                          mod_y_valid_i,
    input  logic [OUT_BITS-1:0]           mod_y_i,
    output logic                          out_strobe_o,
    output logic [OUT_BITS-1:0]           out_y_o,
    output logic                          underrun_o,
    output logic                          late_o
);

    localparam int PTR_BITS = $clog2(FIFO_DEPTH);
    localparam int LVL_BITS = PTR_BITS + 1;

    logic [PERIOD_BITS-1:0] periodCnt_q, periodCnt_d;
    logic [OSR_BITS-1:0]    osrCnt_q, osrCnt_d;
    logic                   pending_q, pending_d;
    logic [IN_BITS-1:0]     modU_q, modU_d;
    logic [OUT_BITS-1:0]    outY_q, outY_d;
    logic                   outStrobe_q, outStrobe_d;
    logic                   underrun_q, underrun_d;
    logic                   late_q, late_d;
    logic [PTR_BITS-1:0]    rdPtr_q, rdPtr_d;
    logic [PTR_BITS-1:0]    wrPtr_q, wrPtr_d;
    logic [LVL_BITS-1:0]    fifoLevel_q, fifoLevel_d;
    logic [IN_BITS-1:0]     fifoMem_q [FIFO_DEPTH];

    logic tick;
    logic take;
    logic pop;
    logic popData;
    logic push;
    logic fifoEmpty;
    logic lateEvent;
    logic underrunEvent;

    // A full FIFO that pops this cycle still reports not-ready; the freed
    // slot becomes visible once the level register updates.
    assign in_ready_o = (fifoLevel_q != LVL_BITS'(FIFO_DEPTH));

    // The modulator free-runs until it has an output ready, then stalls
    // until that word is taken.
    assign mod_en_o = run_i && (!mod_y_valid_i || take);

    // Pacing events: tick, take, pop, and the flag-raising conditions.
    always_comb begin
        tick          = run_i && (periodCnt_q == '0);
        take          = run_i && (pending_q || tick) && mod_y_valid_i;
        pop           = take && (osrCnt_q == '0);
        fifoEmpty     = (fifoLevel_q == '0);
        popData       = pop && !fifoEmpty;
        push          = in_valid_i && in_ready_o;
        // A tick is late if the modulator is not ready, or if an earlier
        // tick is still waiting (the second one is absorbed).
        lateEvent     = tick && (!mod_y_valid_i || pending_q);
        underrunEvent = pop && fifoEmpty;
    end

    // Next-state logic for counters, pending, output word, flags and FIFO.
    always_comb begin
        periodCnt_d = periodCnt_q;
        osrCnt_d    = osrCnt_q;
        pending_d   = pending_q;
        modU_d      = modU_q;
        outY_d      = outY_q;
        outStrobe_d = take;
        underrun_d  = underrun_q;
        late_d      = late_q;
        rdPtr_d     = rdPtr_q;
        wrPtr_d     = wrPtr_q;
        fifoLevel_d = fifoLevel_q;

        // Config values are only picked up at reload, and while stopped
        // the counters sit at their reload values.
        if (!run_i || tick) begin
            periodCnt_d = period_cfg_i;
        end else begin
            periodCnt_d = periodCnt_q - 1'b1;
        end

        if (!run_i) begin
            osrCnt_d = osr_cfg_i;
        end else if (take) begin
            if (osrCnt_q == '0) begin
                osrCnt_d = osr_cfg_i;
            end else begin
                osrCnt_d = osrCnt_q - 1'b1;
            end
        end

        if (!run_i || take) begin
            pending_d = 1'b0;
        end else if (tick) begin
            pending_d = 1'b1;
        end

        if (take) begin
            outY_d = mod_y_i;
        end

        if (popData) begin
            modU_d  = fifoMem_q[rdPtr_q];
            rdPtr_d = rdPtr_q + 1'b1;
        end else if (underrunEvent) begin
`ifdef DS_PACER_UNDERRUN_MUTE_EN
            modU_d = '0;
`else
            modU_d = modU_q;
`endif
        end

        if (push) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end

        case ({push, popData})
            2'b10:   fifoLevel_d = fifoLevel_q + 1'b1;
            2'b01:   fifoLevel_d = fifoLevel_q - 1'b1;
            default: fifoLevel_d = fifoLevel_q;
        endcase

        // A set event in the same cycle beats a clear request.
        if (underrunEvent) begin
            underrun_d = 1'b1;
        end else if (clear_flags_i) begin
            underrun_d = 1'b0;
        end

        if (lateEvent) begin
            late_d = 1'b1;
        end else if (clear_flags_i) begin
            late_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            periodCnt_q <= period_cfg_i;
            osrCnt_q    <= osr_cfg_i;
            pending_q   <= 1'b0;
            modU_q      <= '0;
            outY_q      <= '0;
            outStrobe_q <= 1'b0;
            underrun_q  <= 1'b0;
            late_q      <= 1'b0;
            rdPtr_q     <= '0;
            wrPtr_q     <= '0;
            fifoLevel_q <= '0;
        end else begin
            periodCnt_q <= periodCnt_d;
            osrCnt_q    <= osrCnt_d;
            pending_q   <= pending_d;
            modU_q      <= modU_d;
            outY_q      <= outY_d;
            outStrobe_q <= outStrobe_d;
            underrun_q  <= underrun_d;
            late_q      <= late_d;
            rdPtr_q     <= rdPtr_d;
            wrPtr_q     <= wrPtr_d;
            fifoLevel_q <= fifoLevel_d;
        end
    end

    // FIFO storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= in_sample_i;
        end
    end

    assign fifo_level_o = fifoLevel_q;
    assign mod_u_o      = modU_q;
    assign out_strobe_o = outStrobe_q;
    assign out_y_o      = outY_q;
    assign underrun_o   = underrun_q;
    assign late_o       = late_q;

endmodule

// File: tb/tb_ds_sample_pacer.sv
// ---------------------------------------------------------------------------
// tb_ds_sample_pacer
//
// Bench for ds_sample_pacer. A small modulator stand-in needs 12 enabled
// clocks per output word and then stalls with its word valid until enabled
// again. A reference model tracks the FIFO as a queue and derives ticks, takes
// and pops from run-cycle and take counts with plain modulo arithmetic.
// ---------------------------------------------------------------------------
module tb_ds_sample_pacer;

    localparam int IN_BITS     = 16;
    localparam int OUT_BITS    = 7;
    localparam int FIFO_DEPTH  = 4;
    localparam int PERIOD_BITS = 8;
    localparam int OSR_BITS    = 8;
    localparam int MOD_LAT     = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   reset;
    logic                   run;
    logic [PERIOD_BITS-1:0] periodCfg;
    logic [OSR_BITS-1:0]    osrCfg;
    logic                   clearFlags;
    logic                   inValid;
    logic                   inReady;
    logic [IN_BITS-1:0]     inSample;
    logic [2:0]             fifoLevel;
    logic                   modEn;
    logic [IN_BITS-1:0]     modU;
    logic                   modYValid;
    logic [OUT_BITS-1:0]    modY;
    logic                   outStrobe;
    logic [OUT_BITS-1:0]    outY;
    logic                   underrun;
    logic                   late;

    int checkCount = 0;
    int failCount  = 0;

    ds_sample_pacer #(
        .IN_BITS     (IN_BITS),
        .OUT_BITS    (OUT_BITS),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .PERIOD_BITS (PERIOD_BITS),
        .OSR_BITS    (OSR_BITS)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .run_i         (run),
        .period_cfg_i  (periodCfg),
        .osr_cfg_i     (osrCfg),
        .clear_flags_i (clearFlags),
        .in_valid_i    (inValid),
        .in_ready_o    (inReady),
        .in_sample_i   (inSample),
        .fifo_level_o  (fifoLevel),
        .mod_en_o      (modEn),
        .mod_u_o       (modU),
        .mod_y_valid_i (modYValid),
        .mod_y_i       (modY),
        .out_strobe_o  (outStrobe),
        .out_y_o       (outY),
        .underrun_o    (underrun),
        .late_o        (late)
    );

    // Modulator stand-in: 12 enabled clocks per word, holds the word valid
    // until it is enabled again, restarts on the enabled valid cycle.
    logic [3:0] modPhase;
    logic [6:0] modIter;
    assign modYValid = (modPhase == 4'(MOD_LAT));

    always_ff @(posedge clk) begin
        if (reset) begin
            modPhase <= 4'd0;
            modIter  <= 7'd0;
            modY     <= '0;
        end else if (modEn) begin
            if (modYValid) begin
                modPhase <= 4'd1;
            end else begin
                modPhase <= modPhase + 4'd1;
            end
            if (modPhase == 4'(MOD_LAT - 1)) begin
                modY    <= modU[15:9] ^ modIter;
                modIter <= modIter + 7'd1;
            end
        end
    end

    // Reference model state.
    logic [IN_BITS-1:0]  mQ[$];
    logic [IN_BITS-1:0]  mU;
    logic [OUT_BITS-1:0] mY;
    bit                  mStrobe;
    bit                  mUnder;
    bit                  mLate;
    bit                  mPending;
    int                  mRunCycles;
    int                  mTakes;

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mQ.delete();
        mU         = '0;
        mY         = '0;
        mStrobe    = 1'b0;
        mUnder     = 1'b0;
        mLate      = 1'b0;
        mPending   = 1'b0;
        mRunCycles = 0;
        mTakes     = 0;
    endtask

    // One clock: drive inputs, compare against the model, advance the model.
    task automatic applyStimulus(input bit rstIn, input bit runIn, input int pIn, input int oIn,
                                 input bit clrIn, input bit vIn, input logic [IN_BITS-1:0] sIn,
                                 input bit doCheck);
        bit tick, take, pop, expEn, expReady, lateEv, yv;
        logic [OUT_BITS-1:0] yIn;
        @(negedge clk);
        reset      = rstIn;
        run        = runIn;
        periodCfg  = PERIOD_BITS'(pIn);
        osrCfg     = OSR_BITS'(oIn);
        clearFlags = clrIn;
        inValid    = vIn;
        inSample   = sIn;
        #1;
        yv       = modYValid;
        yIn      = modY;
        tick     = runIn && ((mRunCycles % (pIn + 1)) == pIn);
        take     = runIn && (mPending || tick) && yv;
        pop      = take && ((mTakes % (oIn + 1)) == oIn);
        expEn    = runIn && (!yv || take);
        expReady = (mQ.size() != FIFO_DEPTH);
        lateEv   = tick && (!yv || mPending);
        if (doCheck) begin
            checkOutput("modEn",     32'(modEn),     32'(expEn));
            checkOutput("inReady",   32'(inReady),   32'(expReady));
            checkOutput("fifoLevel", 32'(fifoLevel), 32'(mQ.size()));
            checkOutput("modU",      32'(modU),      32'(mU));
            checkOutput("outY",      32'(outY),      32'(mY));
            checkOutput("outStrobe", 32'(outStrobe), 32'(mStrobe));
            checkOutput("underrun",  32'(underrun),  32'(mUnder));
            checkOutput("late",      32'(late),      32'(mLate));
        end
        if (rstIn) begin
            modelReset();
        end else begin
            if (pop && mQ.size() == 0) begin
                mUnder = 1'b1;
`ifdef DS_PACER_UNDERRUN_MUTE_EN
                mU = '0;
`endif
            end else begin
                if (clrIn) mUnder = 1'b0;
                if (pop) mU = mQ.pop_front();
            end
            if (lateEv) mLate = 1'b1;
            else if (clrIn) mLate = 1'b0;
            if (vIn && expReady) mQ.push_back(sIn);
            mStrobe = take;
            if (take) mY = yIn;
            if (!runIn || take) mPending = 1'b0;
            else if (tick) mPending = 1'b1;
            mRunCycles = runIn ? mRunCycles + 1 : 0;
            if (!runIn) mTakes = 0;
            else if (take) mTakes = mTakes + 1;
        end
    endtask

    initial begin
        logic [IN_BITS-1:0] drainExp;
        reset      = 1'b1;
        run        = 1'b0;
        periodCfg  = 8'd15;
        osrCfg     = 8'd0;
        clearFlags = 1'b0;
        inValid    = 1'b0;
        inSample   = '0;
        modelReset();

        applyStimulus(1, 0, 15, 0, 0, 0, 16'h0, 0);
        applyStimulus(1, 0, 15, 0, 0, 0, 16'h0, 0);

        // Empty FIFO, one output per 16 clocks, every take pops.
        applyStimulus(0, 0, 15, 0, 0, 0, 16'h0, 1);
        for (int i = 0; i < 60; i++) applyStimulus(0, 1, 15, 0, 0, 0, 16'h0, 1);
        checkOutput("s1Underrun", 32'(underrun), 32'd1);
        checkOutput("s1ModU",     32'(modU),     32'd0);

        // Fill the FIFO while stopped; fifth sample has to wait.
        applyStimulus(0, 0, 15, 3, 1, 0, 16'h0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 15, 3, 0, 1, 16'((i + 1) * 4096), 1);
        applyStimulus(0, 0, 15, 3, 0, 1, 16'h5000, 1);
        applyStimulus(0, 0, 15, 3, 0, 1, 16'h5000, 1);
        checkOutput("s2InReady", 32'(inReady),   32'd0);
        checkOutput("s2Level",   32'(fifoLevel), 32'd4);
        for (int i = 0; i < 200; i++) applyStimulus(0, 1, 15, 3, 0, (i < 120), 16'h5000, 1);
        checkOutput("s2ModU", 32'(modU), 32'h3000);

        // Period shorter than the modulator latency.
        applyStimulus(0, 0, 3, 0, 1, 0, 16'h0, 1);
        for (int i = 0; i < 80; i++) applyStimulus(0, 1, 3, 0, 0, 0, 16'h0, 1);
        checkOutput("s3Late", 32'(late), 32'd1);
        applyStimulus(0, 0, 3, 0, 1, 0, 16'h0, 1);
        applyStimulus(0, 0, 3, 0, 0, 0, 16'h0, 1);
        checkOutput("s3LateCleared", 32'(late), 32'd0);

        // Drain a single full-scale sample, then underrun.
        applyStimulus(1, 0, 15, 0, 0, 0, 16'h0, 1);
        applyStimulus(0, 0, 15, 0, 0, 1, 16'h7FFF, 1);
        for (int i = 0; i < 50; i++) applyStimulus(0, 1, 15, 0, 0, 0, 16'h0, 1);
`ifdef DS_PACER_UNDERRUN_MUTE_EN
        drainExp = 16'h0000;
`else
        drainExp = 16'h7FFF;
`endif
        checkOutput("s4ModU",     32'(modU),     32'(drainExp));
        checkOutput("s4Underrun", 32'(underrun), 32'd1);

        // Push into an empty FIFO in the same cycle as the first pop.
        applyStimulus(1, 0, 15, 0, 0, 0, 16'h0, 1);
        applyStimulus(0, 0, 15, 0, 0, 0, 16'h0, 1);
        for (int i = 0; i < 17; i++) applyStimulus(0, 1, 15, 0, 0, (i == 15), 16'h2468, 1);
        checkOutput("s5Level",    32'(fifoLevel), 32'd1);
        checkOutput("s5Underrun", 32'(underrun),  32'd1);
        checkOutput("s5ModUHeld", 32'(modU),      32'd0);
        for (int i = 17; i < 40; i++) applyStimulus(0, 1, 15, 0, 0, 0, 16'h0, 1);
        checkOutput("s5ModU", 32'(modU), 32'h2468);

        // Reset in the middle of a period with three samples queued.
        applyStimulus(0, 0, 40, 0, 0, 0, 16'h0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 40, 0, 0, 1, 16'(16'h0100 + i), 1);
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, 40, 0, 0, 0, 16'h0, 1);
        checkOutput("s6LevelBefore", 32'(fifoLevel), 32'd3);
        applyStimulus(1, 1, 40, 0, 0, 0, 16'h0, 1);
        applyStimulus(0, 0, 40, 0, 0, 0, 16'h0, 1);
        checkOutput("s6Level",    32'(fifoLevel), 32'd0);
        checkOutput("s6InReady",  32'(inReady),   32'd1);
        checkOutput("s6Underrun", 32'(underrun),  32'd0);
        checkOutput("s6ModU",     32'(modU),      32'd0);
        checkOutput("s6Strobe",   32'(outStrobe), 32'd0);

        // Randomized rounds: new config each round while stopped.
        for (int r = 0; r < 10; r++) begin
            int p, o;
            p = int'($urandom_range(3, 20));
            o = int'($urandom_range(0, 3));
            for (int i = 0; i < 2; i++)
                applyStimulus(0, 0, p, o, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                              16'($urandom), 1);
            for (int i = 0; i < 150; i++)
                applyStimulus(0, 1, p, o, ($urandom_range(0, 31) == 0), ($urandom_range(0, 9) < 3),
                              16'($urandom), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/ds_sample_pacer.md
# ds_sample_pacer

Controller that sequences the delta-sigma modulator datapath at a fixed output rate. Buffers incoming PCM samples in a small FIFO and presents the current sample on the modulator's `u` input. Gates the modulator enable so that exactly one output word is taken every `period_cfg+1` clocks, and advances to the next input sample every `osr_cfg+1` output words. Sits between the sample source (host or register interface) and `delta_sigma_modulator`, replacing PWM-driven pacing when the output feeds a plain DAC or serializer.

## Interface
Parameters:
- `IN_BITS`, 16, sample width, equal to the modulator `IN_BITS`
- `OUT_BITS`, 7, modulator output width
- `FIFO_DEPTH`, 4, input FIFO entries (power of two, ≥2)
- `PERIOD_BITS`, 8, width of `period_cfg`
- `OSR_BITS`, 8, width of `osr_cfg`

Ports:
- `clk` in 1: clock; single clock domain
- `reset` in 1: synchronous, active-high
- `run` in 1: pacing enable
- `period_cfg` in PERIOD_BITS: output period minus 1, in clocks
- `osr_cfg` in OSR_BITS: outputs per input sample minus 1
- `clear_flags` in 1: clears the sticky flags
- `in_valid` in 1, `in_ready` out 1, `in_sample` in IN_BITS: sample push handshake
- `fifo_level` out clog2(FIFO_DEPTH)+1: current number of FIFO entries
- `mod_en` out 1: modulator `en`
- `mod_u` out IN_BITS: modulator `u`
- `mod_y_valid` in 1, `mod_y` in OUT_BITS: modulator `y_valid_out` and `y`
- `out_strobe` out 1: one-cycle pulse, new output word
- `out_y` out OUT_BITS: registered output word
- `underrun` out 1: sticky flag
- `late` out 1: sticky flag

## Operation
- Reset values:
  - `mod_u`=0, `out_y`=0, `out_strobe`=0, `underrun`=0, `late`=0, `fifo_level`=0.
  - Period counter = `period_cfg`; OSR counter = `osr_cfg`; pending=0.
- FIFO:
  - Push when `in_valid && in_ready`.
  - `in_ready = (fifo_level != FIFO_DEPTH)`, combinational; it is 1 out of reset.
  - A pop frees space only from the next cycle, so `in_ready` stays 0 in the cycle a full FIFO pops.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - Push and pop in the same cycle leave the level unchanged.
- `run`=0:
  - `mod_en`=0, and both counters are held at reload values.
  - pending is cleared.
  - The FIFO still accepts pushes.
- Period counter (`run`=1):
  - Decrements every clock.
  - At 0 it reloads `period_cfg` and raises the tick.
  - The tick sets pending; pending stays set until it is consumed.
- Take condition: `take = pending_or_tick && mod_y_valid`.
  - `mod_en = !mod_y_valid || take` while `run`=1. The modulator free-runs to its output state, then stalls until the take.
  - On take: `out_y <= mod_y`, `out_strobe`=1 next cycle, pending cleared.
  - If a tick arrives while `mod_y_valid`=0, `late` is set.
  - A second tick while pending is still set is absorbed: one take only, and `late` is set.
- OSR counter:
  - Decrements on each take.
  - On the take where it is 0, it reloads `osr_cfg` and the block pops the FIFO into `mod_u`.
  - The new sample is used from the next modulator iteration.
- Empty FIFO at a pop:
  - `underrun` is set.
  - `mod_u` holds its value (see Configuration).
  - A push in the same cycle does not bypass the FIFO.
- Flags:
  - `clear_flags` clears both flags.
  - A set event in the same cycle wins over the clear.
- Config inputs:
  - `period_cfg`/`osr_cfg` are sampled only at reload.
  - Changes take effect at the next reload.
- `reset` mid-operation:
  - Restores all reset values and empties the FIFO.
  - The downstream modulator is reset by the same `reset`.

## Timing
- `mod_en`, `in_ready`: combinational from state and `mod_y_valid`.
- All other outputs are registered.
- First tick: `period_cfg+1` clocks after `run` rises.
- Then one tick every `period_cfg+1` clocks.
- `out_strobe` follows its take by 1 clock.
- `period_cfg` ≥ 12 guarantees no `late` with the 4-tap modulator (12-state schedule).
- Push to visible in `fifo_level`: 1 clock.
- Pop to `mod_u`: updated 1 clock after the take.

## Configuration
- `DS_PACER_UNDERRUN_MUTE_EN`:
  - Defined: on underrun `mod_u` is loaded with 0 (mute).
  - Not defined: `mod_u` holds the last sample.
  - `underrun` flag behaviour is identical either way.

## Test plan
- Reset, `run`=1, `period_cfg`=15, `osr_cfg`=0, FIFO empty → first `out_strobe` within 17 clocks, then every 16 clocks; `underrun`=1 after first take; `mod_u`=0.
- Push 0x1000, 0x2000, 0x3000, 0x4000, 0x5000 back-to-back → `in_ready`=0 after 4 pushes, 5th waits; `fifo_level`=4; pops occur every 4th strobe with `osr_cfg`=3.
- `period_cfg`=3 → `late`=1, strobes spaced by modulator latency (12 clocks), no strobe lost or duplicated; `clear_flags` with no new late event → `late`=0.
- Drain FIFO holding 0x7FFF, then underrun → `mod_u` stays 0x7FFF (macro off) or becomes 0 (macro on).
- Push into empty FIFO in the same cycle as pop → `underrun`=1, `fifo_level`=1 next cycle, sample popped at next OSR reload.
- Assert `reset` mid-period with FIFO level 3 → next cycle all outputs at reset values, `fifo_level`=0, `in_ready`=1.
